// File: rtl/pid_fifo_pkg.sv
// Shared definitions for the PID order FIFO: USB PID byte values and the
// width helper used for pointer and occupancy sizing.
package pid_fifo_pkg;

  localparam logic [7:0] OUT   = 8'hE1;
  localparam logic [7:0] IN    = 8'h69;
  localparam logic [7:0] SETUP = 8'h2D;
  localparam logic [7:0] DATA0 = 8'hC3;
  localparam logic [7:0] DATA1 = 8'h4B;
  localparam logic [7:0] ACK   = 8'hD2;
  localparam logic [7:0] NAK   = 8'h5A;
  localparam logic [7:0] STALL = 8'h1E;

  // Bits needed to encode n distinct values, never less than 1.
  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer: advances on inc and wraps from DEPTH-1 straight to 0,
// so codes above DEPTH-1 are never visited.
module fifo_wrap_ptr #(
  parameter int DEPTH = 80,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  logic [W-1:0] ptr_reg;
  logic [W-1:0] ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (clear) begin
      ptr_next = '0;
    end else if (inc) begin
      ptr_next = (ptr_reg == LAST) ? '0 : ptr_reg + W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/pid_order_fifo.sv
// First-word-fall-through FIFO recording USB PID arrival order, with occupancy,
// almost-full/empty thresholds, synchronous flush and sticky error flags.
module pid_order_fifo
  import pid_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 80,
  parameter int AF_TH  = 76,
  parameter int AE_TH  = 2
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       clear,
  input  logic                       w_enable,
  input  logic [DATA_W-1:0]          w_data,
  input  logic                       r_enable,
  output logic [DATA_W-1:0]          r_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clear
);

  localparam int PW = clog2_safe(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || AF_TH > DEPTH || AE_TH >= DEPTH) begin : g_bad_params
    $error("pid_order_fifo: illegal DEPTH/AF_TH/AE_TH combination");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push_ok;
  logic          pop_ok;

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          empty_reg;
  logic          full_reg;
  logic          almost_full_reg;
  logic          almost_empty_reg;
  logic          overflow_reg;
  logic          overflow_next;
  logic          underflow_reg;
  logic          underflow_next;

  // A flush wins over any push or pop issued in the same cycle.
  assign push_ok = w_enable & (~full_reg | r_enable) & ~clear;
  assign pop_ok  = r_enable & ~empty_reg & ~clear;

  fifo_wrap_ptr #(.DEPTH(DEPTH), .W(PW)) u_rd_ptr (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .inc   (pop_ok),
    .ptr   (rd_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .W(PW)) u_wr_ptr (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .inc   (push_ok),
    .ptr   (wr_ptr)
  );

  // When full with push+pop, wr_ptr equals rd_ptr: the head is read out this
  // cycle and the slot is rewritten at the edge, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= w_data;
    end
  end

  assign r_data = mem[rd_ptr];

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (push_ok && !pop_ok) begin
      count_next = count_reg + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = count_reg - CW'(1);
    end
  end

  // A new error in the same cycle as err_clear leaves the flag set.
  always_comb begin
    overflow_next  = overflow_reg & ~err_clear;
    underflow_next = underflow_reg & ~err_clear;
    if (w_enable && full_reg && !r_enable && !clear) begin
      overflow_next = 1'b1;
    end
    if (r_enable && empty_reg && !clear) begin
      underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_reg        <= '0;
      empty_reg        <= 1'b1;
      full_reg         <= 1'b0;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      count_reg        <= count_next;
      empty_reg        <= (count_next == '0);
      full_reg         <= (count_next == CW'(DEPTH));
      almost_full_reg  <= (count_next >= CW'(AF_TH));
      almost_empty_reg <= (count_next <= CW'(AE_TH));
      overflow_reg     <= overflow_next;
      underflow_reg    <= underflow_next;
    end
  end

  assign count        = count_reg;
  assign empty        = empty_reg;
  assign full         = full_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_pid_order_fifo.sv
// Self-checking bench for pid_order_fifo: directed scenarios plus a randomized
// run, all checked against a queue-based reference model.
module tb_pid_order_fifo;
  import pid_fifo_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 80;
  localparam int AF_TH  = 76;
  localparam int AE_TH  = 2;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              clear = 1'b0;
  logic              w_enable = 1'b0;
  logic [DATA_W-1:0] w_data = '0;
  logic              r_enable = 1'b0;
  logic              err_clear = 1'b0;
  logic [DATA_W-1:0] r_data;
  logic              empty, full, almost_full, almost_empty;
  logic [CW-1:0]     count;
  logic              overflow, underflow;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: contents in arrival order plus the two sticky flags.
  logic [DATA_W-1:0] q[$];
  bit                m_ovf = 1'b0;
  bit                m_unf = 1'b0;

  always #5 clk = ~clk;

  pid_order_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .w_enable     (w_enable),
    .w_data       (w_data),
    .r_enable     (r_enable),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clear    (err_clear)
  );

  // Called at a falling edge: apply one cycle of inputs, advance the model at
  // the rising edge, return at the next falling edge with inputs idle.
  task automatic step(input bit we, input logic [DATA_W-1:0] wd, input bit re,
                      input bit cl, input bit ec);
    int  sz;
    bit  was_full, was_empty;
    w_enable = we; w_data = wd; r_enable = re; clear = cl; err_clear = ec;
    @(posedge clk);
    sz = q.size();
    was_full = (sz == DEPTH);
    was_empty = (sz == 0);
    if (ec) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (cl) begin
      q.delete();
    end else begin
      if (we && was_full && !re) m_ovf = 1'b1;
      if (re && was_empty) m_unf = 1'b1;
      if (re && !was_empty) void'(q.pop_front());
      if (we && (!was_full || re)) q.push_back(wd);
    end
    @(negedge clk);
    w_enable = 1'b0; r_enable = 1'b0; clear = 1'b0; err_clear = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({empty, full, almost_full, almost_empty, overflow, underflow} !== 6'b100100) begin
      n_err++;
      $display("FAIL reset_flags_held: got %b want 100100",
               {empty, full, almost_full, almost_empty, overflow, underflow});
    end
    n_rst = 1'b1;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({empty, full, almost_full, almost_empty, overflow, underflow} !== 6'b100100) begin
      n_err++;
      $display("FAIL reset_flags_idle: got %b want 100100",
               {empty, full, almost_full, almost_empty, overflow, underflow});
    end
    n_vec++;
    if (count !== CW'(0)) begin
      n_err++;
      $display("FAIL reset_count: got %0d want 0", count);
    end
    $display("test_reset done");
  endtask

  task automatic test_order();
    logic [DATA_W-1:0] pids [3];
    int exp_cnt [6];
    pids = '{OUT, DATA0, ACK};
    exp_cnt = '{1, 2, 3, 2, 1, 0};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, pids[i], 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (count !== CW'(exp_cnt[i]) || r_data !== OUT || empty !== 1'b0) begin
        n_err++;
        $display("FAIL order_push%0d: got count=%0d r_data=%h empty=%b want count=%0d r_data=%h empty=0",
                 i, count, r_data, empty, exp_cnt[i], OUT);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (r_data !== pids[i]) begin
        n_err++;
        $display("FAIL order_pop%0d_data: got %h want %h", i, r_data, pids[i]);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (count !== CW'(exp_cnt[3+i])) begin
        n_err++;
        $display("FAIL order_pop%0d_count: got %0d want %0d", i, count, exp_cnt[3+i]);
      end
    end
    n_vec++;
    if (empty !== 1'b1 || almost_empty !== 1'b1) begin
      n_err++;
      $display("FAIL order_drained: got empty=%b almost_empty=%b want 1 1", empty, almost_empty);
    end
    $display("test_order done");
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      n_vec++;
      if (count !== CW'(i + 1) || almost_full !== (i + 1 >= AF_TH) || full !== (i + 1 == DEPTH)
          || almost_empty !== (i + 1 <= AE_TH)) begin
        n_err++;
        $display("FAIL fill_%0d: got count=%0d af=%b full=%b ae=%b want count=%0d af=%b full=%b ae=%b",
                 i, count, almost_full, full, almost_empty, i + 1, (i + 1 >= AF_TH),
                 (i + 1 == DEPTH), (i + 1 <= AE_TH));
      end
    end
    step(1'b1, NAK, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (overflow !== 1'b1 || count !== CW'(DEPTH) || r_data !== 8'h00 || full !== 1'b1) begin
      n_err++;
      $display("FAIL fill_overflow: got ovf=%b count=%0d head=%h full=%b want ovf=1 count=%0d head=00 full=1",
               overflow, count, r_data, full, DEPTH);
    end
    $display("test_fill done");
  endtask

  task automatic test_full_push_pop();
    logic [DATA_W-1:0] exp;
    for (int i = 0; i < 90; i++) begin
      exp = q[0];
      n_vec++;
      if (r_data !== exp) begin
        n_err++;
        $display("FAIL full_pp_data_%0d: got %h want %h", i, r_data, exp);
      end
      step(1'b1, 8'(DATA1 + 8'(i)), 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (count !== CW'(DEPTH) || full !== 1'b1) begin
        n_err++;
        $display("FAIL full_pp_count_%0d: got count=%0d full=%b want %0d 1", i, count, full, DEPTH);
      end
    end
    n_vec++;
    if (r_data !== q[0]) begin
      n_err++;
      $display("FAIL full_pp_final_head: got %h want %h", r_data, q[0]);
    end
    $display("test_full_push_pop done");
  endtask

  task automatic test_empty_push_pop();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (empty !== 1'b1 || count !== CW'(0) || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL flush_full: got empty=%b count=%0d ovf=%b want 1 0 1", empty, count, overflow);
    end
    step(1'b1, IN, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (underflow !== 1'b1 || count !== CW'(1) || r_data !== IN || empty !== 1'b0) begin
      n_err++;
      $display("FAIL empty_pp: got unf=%b count=%0d r_data=%h empty=%b want 1 1 %h 0",
               underflow, count, r_data, empty, IN);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (underflow !== 1'b0 || overflow !== 1'b0 || count !== CW'(1)) begin
      n_err++;
      $display("FAIL err_clear: got unf=%b ovf=%b count=%0d want 0 0 1", underflow, overflow, count);
    end
    $display("test_empty_push_pop done");
  endtask

  task automatic test_clear();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(SETUP + 8'(i)), 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (count !== CW'(5) || underflow !== 1'b1) begin
      n_err++;
      $display("FAIL clear_setup: got count=%0d unf=%b want 5 1", count, underflow);
    end
    step(1'b1, STALL, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (empty !== 1'b1 || count !== CW'(0) || underflow !== 1'b1 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL clear_with_push: got empty=%b count=%0d unf=%b ovf=%b want 1 0 1 0",
               empty, count, underflow, overflow);
    end
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    n_vec++;
    if (underflow !== 1'b0 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL clear_masks_underflow: got unf=%b empty=%b want 0 1", underflow, empty);
    end
    $display("test_clear done");
  endtask

  task automatic test_async_reset();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(ACK ^ 8'(i)), 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (underflow !== 1'b1 || count !== CW'(3)) begin
      n_err++;
      $display("FAIL async_setup: got unf=%b count=%0d want 1 3", underflow, count);
    end
    w_enable = 1'b1; w_data = OUT;
    #2 n_rst = 1'b0;
    #1;
    n_vec++;
    if ({empty, full, almost_full, almost_empty, overflow, underflow} !== 6'b100100
        || count !== CW'(0)) begin
      n_err++;
      $display("FAIL async_reset: got flags=%b count=%0d want 100100 0",
               {empty, full, almost_full, almost_empty, overflow, underflow}, count);
    end
    @(negedge clk);
    w_enable = 1'b0;
    n_rst = 1'b1;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (count !== CW'(0) || empty !== 1'b1) begin
      n_err++;
      $display("FAIL async_release: got count=%0d empty=%b want 0 1", count, empty);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    bit we, re, cl, ec;
    int sz;
    int pct;
    for (int i = 0; i < 3000; i++) begin
      pct = ((i / 300) % 2 == 0) ? 70 : 30;
      we = ($urandom_range(99) < pct);
      re = ($urandom_range(99) < 100 - pct);
      cl = ($urandom_range(149) == 0);
      ec = ($urandom_range(39) == 0);
      step(we, 8'($urandom), re, cl, ec);
      sz = q.size();
      n_vec++;
      if (count !== CW'(sz) || empty !== (sz == 0) || full !== (sz == DEPTH)
          || almost_full !== (sz >= AF_TH) || almost_empty !== (sz <= AE_TH)
          || overflow !== m_ovf || underflow !== m_unf) begin
        n_err++;
        $display("FAIL rand_state_%0d: got count=%0d e=%b f=%b af=%b ae=%b ovf=%b unf=%b want count=%0d e=%b f=%b af=%b ae=%b ovf=%b unf=%b",
                 i, count, empty, full, almost_full, almost_empty, overflow, underflow,
                 sz, (sz == 0), (sz == DEPTH), (sz >= AF_TH), (sz <= AE_TH), m_ovf, m_unf);
      end
      if (sz > 0) begin
        n_vec++;
        if (r_data !== q[0]) begin
          n_err++;
          $display("FAIL rand_head_%0d: got %h want %h", i, r_data, q[0]);
        end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_order();
    test_fill();
    test_full_push_pop();
    test_empty_push_pop();
    test_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
